// File: rtl/detector_frame_sequencer.sv
// Frame sequencer for the 110101 detector: serialises a parallel frame MSB-first,
// issues one clk_en strobe per bit (divider or manual step) and counts detector hits.
module detector_frame_sequencer #(
   parameter int WIDTH  = 16,
   parameter int PERIOD = 4,
   parameter int DRAIN  = 2,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] frame_in,
   input  logic             frame_valid,
   output logic             frame_ready,
   input  logic             auto_mode,
   input  logic             step_in,
   input  logic             abort,
   input  logic             det_hit,
   output logic             ser_in_o,
   output logic             clk_en_o,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] hit_count
);

   localparam int BC_W  = $clog2(WIDTH + 1);
   localparam int DIV_W = $clog2(PERIOD);
   localparam int DR_W  = $clog2(DRAIN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DR_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] hit_count_q, hit_count_d;
   logic             tick;
   logic             strobe;
   logic             counting;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         div_q       <= '0;
         drain_cnt_q <= '0;
         run_cnt_q   <= '0;
         hit_count_q <= '0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         div_q       <= div_d;
         drain_cnt_q <= drain_cnt_d;
         run_cnt_q   <= run_cnt_d;
         hit_count_q <= hit_count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      div_d       = div_q;
      drain_cnt_d = drain_cnt_q;
      run_cnt_d   = run_cnt_q;
      hit_count_d = hit_count_q;

      tick     = auto_mode ? (div_q == DIV_W'(PERIOD - 1)) : step_in;
      // abort outranks a coincident tick so the detector never sees a stray strobe
      strobe   = (state_q == S_SHIFT) && tick && !abort;
      counting = (state_q == S_SHIFT) || (state_q == S_DRAIN);

      if (counting && det_hit && (run_cnt_q != CNT_MAX))
         run_cnt_d = run_cnt_q + CNT_W'(1);

      case (state_q)
         S_IDLE: begin
            if (frame_valid) begin
               state_d   = S_SHIFT;
               shreg_d   = frame_in;
               bit_cnt_d = '0;
               div_d     = '0;
               run_cnt_d = '0;
            end
         end
         S_SHIFT: begin
            // divider free-runs through the frame so a mode switch keeps its phase
            div_d = (div_q == DIV_W'(PERIOD - 1)) ? '0 : div_q + DIV_W'(1);
            if (abort) begin
               state_d = S_IDLE;
            end else if (strobe) begin
               shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + BC_W'(1);
               if (bit_cnt_q == BC_W'(WIDTH - 1)) begin
                  state_d     = S_DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (drain_cnt_q == DR_W'(DRAIN - 1)) begin
               state_d     = S_DONE;
               hit_count_d = run_cnt_d;
            end else begin
               drain_cnt_d = drain_cnt_q + DR_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign frame_ready = (state_q == S_IDLE);
   assign busy        = counting;
   assign done        = (state_q == S_DONE);
   assign ser_in_o    = (state_q == S_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
   assign clk_en_o    = strobe;
   assign hit_count   = hit_count_q;

endmodule

// File: tb/tb_detector_frame_sequencer.sv
// Randomised bench for detector_frame_sequencer with a behavioural 110101 detector
// and per-frame expectations computed from the frame bits.
module tb_detector_frame_sequencer;

   localparam int WIDTH  = 16;
   localparam int PERIOD = 4;
   localparam int DRAIN  = 2;
   localparam int CNT_W  = 4;
   localparam int SAT    = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] frame_in = '0;
   logic             frame_valid = 1'b0;
   logic             frame_ready;
   logic             auto_mode = 1'b1;
   logic             step_in = 1'b0;
   logic             abort = 1'b0;
   logic             det_hit;
   logic             ser_in_o;
   logic             clk_en_o;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] hit_count;

   detector_frame_sequencer #(
      .WIDTH(WIDTH), .PERIOD(PERIOD), .DRAIN(DRAIN), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .auto_mode(auto_mode), .step_in(step_in),
      .abort(abort), .det_hit(det_hit), .ser_in_o(ser_in_o), .clk_en_o(clk_en_o),
      .busy(busy), .done(done), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // behavioural detector: one-cycle hit after the strobe that completes 110101
   logic       det_force = 1'b0;
   logic [5:0] hist;
   int         nb;
   logic       det_q;
   assign det_hit = det_force | det_q;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist  <= '0;
         nb    <= 0;
         det_q <= 1'b0;
      end else begin
         if (frame_valid && frame_ready) begin
            hist <= '0;
            nb   <= 0;
         end else if (clk_en_o) begin
            hist <= {hist[4:0], ser_in_o};
            nb   <= nb + 1;
         end
         det_q <= clk_en_o && (nb >= 5) && ({hist[4:0], ser_in_o} == 6'b110101);
      end
   end

   // observation of DUT outputs mid-cycle
   int               cyc = 0;
   int               strobes = 0;
   int               dones = 0;
   int               done_t = 0;
   int               accepts = 0;
   int               viol = 0;
   logic [WIDTH-1:0] cap = '0;
   int               times[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (clk_en_o) begin
         strobes <= strobes + 1;
         cap     <= {cap[WIDTH-2:0], ser_in_o};
         times.push_back(cyc);
      end
      if (done) begin
         dones  <= dones + 1;
         done_t <= cyc;
      end
      if (frame_valid && frame_ready) accepts <= accepts + 1;
      if ((frame_ready && (busy || done)) || (!busy && (clk_en_o || ser_in_o)))
         viol <= viol + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_hits(input logic [WIDTH-1:0] f);
      int c = 0;
      logic [5:0] w;
      for (int i = 0; i <= WIDTH - 6; i++) begin
         w = f[WIDTH-1-i -: 6];
         if (w == 6'b110101) c++;
      end
      return (c > SAT) ? SAT : c;
   endfunction

   int acc = 0;

   task automatic accept(input logic [WIDTH-1:0] f);
      frame_in    = f;
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
      acc = cyc;
   endtask

   task automatic run_frame(input logic [WIDTH-1:0] f, input bit am, input bit force_hit,
                            input int exp_hc);
      int s0, d0, t0, n, issued, gap, bad;
      s0 = strobes; d0 = dones; t0 = times.size();
      auto_mode = am;
      det_force = force_hit;
      @(negedge clk);
      chk("ready_idle", 32'(frame_ready), 32'(1));
      step();
      accept(f);
      @(negedge clk);
      chk("busy_after_accept", 32'(busy), 32'(1));
      n = 0; issued = 0; gap = 0;
      while (dones == d0 && n < 3000) begin
         if (am) begin
            step_in = 1'($urandom_range(0, 1));
         end else if (issued < WIDTH && gap == 0) begin
            step_in = 1'b1;
            issued++;
            gap = $urandom_range(1, 3);
         end else begin
            step_in = 1'b0;
            if (gap > 0) gap--;
         end
         step();
         n++;
      end
      step_in   = 1'b0;
      det_force = 1'b0;
      chk("done_once", 32'(dones - d0), 32'(1));
      chk("strobe_count", 32'(strobes - s0), 32'(WIDTH));
      chk("ser_bits", 32'(cap), 32'(f));
      chk("hit_count", 32'(hit_count), 32'(exp_hc));
      chk("ready_after_done", 32'(frame_ready), 32'(1));
      if (times.size() >= t0 + WIDTH) begin
         chk("done_latency", 32'(done_t - times[t0+WIDTH-1]), 32'(DRAIN + 1));
         if (am) begin
            bad = 0;
            for (int i = 1; i < WIDTH; i++)
               if (times[t0+i] - times[t0+i-1] != PERIOD) bad++;
            chk("first_strobe", 32'(times[t0] - acc), 32'(PERIOD - 1));
            chk("strobe_spacing", 32'(bad), 32'(0));
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, d0, a0, v0, n, hc_prev;
      logic [WIDTH-1:0] f;

      // reset values, no clock edge yet
      #3;
      chk("rst_ready", 32'(frame_ready), 32'(1));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_clk_en", 32'(clk_en_o), 32'(0));
      chk("rst_ser_in", 32'(ser_in_o), 32'(0));
      chk("rst_hit_count", 32'(hit_count), 32'(0));
      step();
      step();
      rst = 1'b0;
      step();

      // auto mode, known frame with two overlapping-free 110101 hits
      run_frame(16'b1101_0111_0101_0000, 1'b1, 1'b0, 2);

      // abort in the cycle of strobe 8: no strobe, no done, hit_count kept
      hc_prev = hit_count;
      s0 = strobes; d0 = dones;
      auto_mode = 1'b1;
      det_force = 1'b1;
      accept(16'hABCD);
      n = 0;
      while (strobes - s0 < 7 && n < 200) begin
         step();
         n++;
      end
      chk("abort_reach7", 32'(strobes - s0), 32'(7));
      repeat (3) step();
      abort = 1'b1;
      @(negedge clk);
      chk("abort_beats_tick", 32'(clk_en_o), 32'(0));
      chk("abort_cycle_busy", 32'(busy), 32'(1));
      step();
      abort     = 1'b0;
      det_force = 1'b0;
      @(negedge clk);
      chk("abort_idle_busy", 32'(busy), 32'(0));
      chk("abort_idle_ready", 32'(frame_ready), 32'(1));
      repeat (3) step();
      chk("abort_strobes", 32'(strobes - s0), 32'(7));
      chk("abort_no_done", 32'(dones - d0), 32'(0));
      chk("abort_hc_kept", 32'(hit_count), 32'(hc_prev));
      run_frame(16'b1101_0111_0101_0000, 1'b1, 1'b0, 2);

      // asynchronous reset mid-SHIFT
      accept(16'hFFFF);
      repeat (10) step();
      #2 rst = 1'b1;
      #1;
      chk("midrst_ready", 32'(frame_ready), 32'(1));
      chk("midrst_busy", 32'(busy), 32'(0));
      chk("midrst_clk_en", 32'(clk_en_o), 32'(0));
      chk("midrst_hit_count", 32'(hit_count), 32'(0));
      step();
      rst = 1'b0;
      step();

      // manual stepping: 5 pulses, check, then the remaining 11
      s0 = strobes; d0 = dones;
      auto_mode = 1'b0;
      accept(16'h3535);
      for (int k = 0; k < 5; k++) begin
         step_in = 1'b1; step();
         step_in = 1'b0; step();
      end
      @(negedge clk);
      chk("manual_5_strobes", 32'(strobes - s0), 32'(5));
      chk("manual_busy", 32'(busy), 32'(1));
      step();
      for (int k = 0; k < 11; k++) begin
         step_in = 1'b1; step();
         step_in = 1'b0; step();
      end
      n = 0;
      while (dones == d0 && n < 20) begin
         step();
         n++;
      end
      chk("manual_strobes", 32'(strobes - s0), 32'(WIDTH));
      chk("manual_done", 32'(dones - d0), 32'(1));
      chk("manual_hits", 32'(hit_count), 32'(exp_hits(16'h3535)));
      step_in = 1'b1;
      @(negedge clk);
      chk("idle_step_no_strobe", 32'(clk_en_o), 32'(0));
      step();
      step_in = 1'b0;
      step();

      // saturation with det_hit held across the whole frame
      run_frame(16'h0F0F, 1'b1, 1'b1, SAT);

      // frame_valid held high: one accept per done, only in IDLE
      f = 16'hD75A;
      auto_mode = 1'b1;
      d0 = dones; a0 = accepts; v0 = viol;
      frame_in    = f;
      frame_valid = 1'b1;
      n = 0;
      while (dones - d0 < 2 && n < 400) begin
         step();
         n++;
      end
      frame_valid = 1'b0;
      chk("hs_dones", 32'(dones - d0), 32'(2));
      chk("hs_accepts", 32'(accepts - a0), 32'(2));
      chk("hs_ready_rule", 32'(viol - v0), 32'(0));
      chk("hs_hits", 32'(hit_count), 32'(exp_hits(f)));
      step();

      // random frames in random modes
      for (int r = 0; r < 10; r++) begin
         f = WIDTH'($urandom);
         if (r % 3 == 0) f[WIDTH-1 -: 6] = 6'b110101;
         run_frame(f, 1'($urandom_range(0, 1)), 1'b0, exp_hits(f));
      end

      chk("protocol_violations", 32'(viol), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
